// File: rtl/uart_cmd_assembler.sv
// ============================================================================
// Module   : uart_cmd_assembler
// Purpose  : DUT-side partner of the remote command transmitter.
//            RX path: joins two UART bytes (high, then low) into a 16-bit
//            command. An inter-byte timeout drops a partial frame so that
//            the receiver can resynchronise after a lost byte.
//            TX path: queues 8-bit responses in a 2-entry FIFO and sends
//            them one at a time through the UART trmt/tx_done handshake.
// Ports    : clk, rst_n                    - clock, sync active-low reset
//            rx_data, rx_rdy, clr_rx_rdy   - UART receive handshake
//            cmd, cmd_rdy, clr_cmd_rdy     - assembled command to consumer
//            resp, send_resp               - response push
//            tx_data, trmt, tx_done        - UART transmit handshake
//            resp_sent, frame_err, resp_drop - status pulses
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cmd_assembler #(
  parameter int TIMEOUT_CYC = 2**16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_rdy,
  output logic        clr_rx_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic [7:0]  tx_data,
  output logic        trmt,
  input  logic        tx_done,
  output logic        resp_sent,
  output logic        frame_err,
  output logic        resp_drop
);

  localparam int            CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  // --------------------------------------------------------------------------
  // Receive path
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    WAIT_HIGH = 1'b0,
    WAIT_LOW  = 1'b1
  } rx_state_t;

  rx_state_t        rx_state;
  logic [7:0]       high_byte;
  logic [CNT_W-1:0] to_cnt;
  logic             clr_prev;
  logic             byte_take;

  // The UART drops rx_rdy on the edge after our clear pulse. Ignoring rx_rdy
  // in the cycle right after a clear guarantees one byte is never consumed
  // twice and that clr_rx_rdy can never be high on consecutive cycles.
  assign byte_take  = rst_n & rx_rdy & ~clr_prev;
  assign clr_rx_rdy = byte_take;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state  <= WAIT_HIGH;
      high_byte <= 8'h00;
      to_cnt    <= '0;
      clr_prev  <= 1'b0;
      cmd       <= 16'h0000;
      cmd_rdy   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      clr_prev  <= byte_take;
      frame_err <= 1'b0;

      // The consumer's acknowledge is applied first. Completion of a new
      // command later in this block overrides it.
      if (clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
      end

      case (rx_state)
        WAIT_HIGH: begin
          if (byte_take) begin
            high_byte <= rx_data;
            to_cnt    <= '0;
            cmd_rdy   <= 1'b0;  // never show a stale command once a new frame starts
            rx_state  <= WAIT_LOW;
          end
        end

        WAIT_LOW: begin
          if (byte_take) begin
            // A byte arriving on the timeout cycle itself still completes the frame.
            cmd      <= {high_byte, rx_data};
            cmd_rdy  <= 1'b1;
            rx_state <= WAIT_HIGH;
          end else if (to_cnt == CNT_LAST) begin
            frame_err <= 1'b1;
            high_byte <= 8'h00;
            rx_state  <= WAIT_HIGH;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        default: rx_state <= WAIT_HIGH;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Transmit path
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    TX_IDLE = 1'b0,
    TX_BUSY = 1'b1
  } tx_state_t;

  tx_state_t  tx_state;
  logic [7:0] fifo_mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] fifo_cnt;
  logic       fifo_full;
  logic       pop;
  logic       push;

  assign fifo_full = (fifo_cnt == 2'd2);
  assign pop       = (tx_state == TX_BUSY) & tx_done;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
  assign push      = send_resp & (~fifo_full | pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state    <= TX_IDLE;
      tx_data     <= 8'h00;
      trmt        <= 1'b0;
      resp_sent   <= 1'b0;
      resp_drop   <= 1'b0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
      fifo_mem[0] <= 8'h00;
      fifo_mem[1] <= 8'h00;
    end else begin
      trmt      <= 1'b0;
      resp_sent <= 1'b0;
      resp_drop <= send_resp & ~push;

      if (push) begin
        fifo_mem[wr_ptr] <= resp;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end

      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase

      case (tx_state)
        TX_IDLE: begin
          // tx_done seen here belongs to no byte of ours and is ignored.
          if (fifo_cnt != 2'd0) begin
            tx_data  <= fifo_mem[rd_ptr];
            trmt     <= 1'b1;
            tx_state <= TX_BUSY;
          end
        end

        TX_BUSY: begin
          if (tx_done) begin
            resp_sent <= 1'b1;
            tx_state  <= TX_IDLE;
          end
        end

        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_assembler.sv
// ============================================================================
// Module   : tb_uart_cmd_assembler
// Purpose  : Self-checking bench for uart_cmd_assembler (TIMEOUT_CYC = 16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_cmd_assembler;

  localparam int TO = 16;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic [7:0]  tx_data;
  logic        trmt;
  logic        tx_done;
  logic        resp_sent;
  logic        frame_err;
  logic        resp_drop;

  int total = 0;
  int bad   = 0;

  uart_cmd_assembler #(.TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_rdy      (rx_rdy),
    .clr_rx_rdy  (clr_rx_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .send_resp   (send_resp),
    .tx_data     (tx_data),
    .trmt        (trmt),
    .tx_done     (tx_done),
    .resp_sent   (resp_sent),
    .frame_err   (frame_err),
    .resp_drop   (resp_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [15:0] exp_cmd;
  } frame_vec_t;

  frame_vec_t frames [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a byte as the UART would; the DUT must clear it in the same cycle.
  task automatic send_byte(input string nm, input logic [7:0] b);
    rx_data = b;
    rx_rdy  = 1'b1;
    #1;
    chk({nm, "_clr"}, clr_rx_rdy, 1'b1);
    step();
    rx_rdy = 1'b0;
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_cmd"},       cmd,        16'h0000);
    chk({nm, "_cmd_rdy"},   cmd_rdy,    1'b0);
    chk({nm, "_tx_data"},   tx_data,    8'h00);
    chk({nm, "_trmt"},      trmt,       1'b0);
    chk({nm, "_resp_sent"}, resp_sent,  1'b0);
    chk({nm, "_frame_err"}, frame_err,  1'b0);
    chk({nm, "_resp_drop"}, resp_drop,  1'b0);
    chk({nm, "_clr_rx"},    clr_rx_rdy, 1'b0);
  endtask

  task automatic wait_trmt(input string nm, input logic [7:0] exp);
    int n = 0;
    while (trmt !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({nm, "_trmt"}, trmt, 1'b1);
    chk({nm, "_data"}, tx_data, exp);
  endtask

  task automatic finish_tx(input string nm);
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk({nm, "_sent"}, resp_sent, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; rx_data = 8'h00; rx_rdy = 1'b0; clr_cmd_rdy = 1'b0;
    resp = 8'h00; send_resp = 1'b0; tx_done = 1'b0;

    frames[0] = '{hi: 8'hA5, lo: 8'h3C, exp_cmd: 16'hA53C};
    frames[1] = '{hi: 8'h00, lo: 8'hFF, exp_cmd: 16'h00FF};
    frames[2] = '{hi: 8'hFF, lo: 8'h00, exp_cmd: 16'hFF00};
    frames[3] = '{hi: 8'h12, lo: 8'h34, exp_cmd: 16'h1234};

    step();
    step();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    step();

    // ---------------- table-driven frame assembly ----------------
    for (int i = 0; i < 4; i++) begin
      send_byte("frm_hi", frames[i].hi);
      chk("frm_hi_rdy", cmd_rdy, 1'b0);
      step();
      send_byte("frm_lo", frames[i].lo);
      chk("frm_rdy", cmd_rdy, 1'b1);
      chk("frm_cmd", cmd, frames[i].exp_cmd);
      chk("frm_no_dbl_clr", clr_rx_rdy, 1'b0);
      clr_cmd_rdy = 1'b1;
      step();
      clr_cmd_rdy = 1'b0;
      chk("frm_ack_rdy", cmd_rdy, 1'b0);
      chk("frm_ack_cmd", cmd, frames[i].exp_cmd);
      step();
    end

    // ---------------- inter-byte timeout ----------------
    send_byte("to_hi", 8'h12);
    for (int k = 1; k <= TO; k++) begin
      step();
      chk("to_ferr", frame_err, (k == TO) ? 1'b1 : 1'b0);
    end
    chk("to_cmd_hold", cmd, 16'h1234);
    chk("to_rdy_hold", cmd_rdy, 1'b0);
    step();
    chk("to_ferr_pulse", frame_err, 1'b0);
    send_byte("to_b1", 8'h34);
    step();
    send_byte("to_b2", 8'h56);
    chk("to_cmd", cmd, 16'h3456);
    chk("to_rdy", cmd_rdy, 1'b1);
    step();

    // Low byte on the timeout cycle itself is accepted.
    send_byte("edge_hi", 8'h78);
    for (int k = 1; k < TO; k++) begin
      step();
      chk("edge_ferr", frame_err, 1'b0);
    end
    send_byte("edge_lo", 8'h9A);
    chk("edge_cmd", cmd, 16'h789A);
    chk("edge_rdy", cmd_rdy, 1'b1);
    chk("edge_ferr_now", frame_err, 1'b0);
    step();
    chk("edge_ferr_after", frame_err, 1'b0);

    // ---------------- set wins over clear ----------------
    send_byte("sw_hi", 8'hC3);
    chk("sw_hi_clears", cmd_rdy, 1'b0);
    step();
    rx_data = 8'hD4;
    rx_rdy = 1'b1;
    clr_cmd_rdy = 1'b1;
    step();
    rx_rdy = 1'b0;
    clr_cmd_rdy = 1'b0;
    chk("sw_rdy", cmd_rdy, 1'b1);
    chk("sw_cmd", cmd, 16'hC3D4);
    step();
    send_byte("sw_next_hi", 8'h01);
    chk("sw_next_clears", cmd_rdy, 1'b0);
    chk("sw_cmd_kept", cmd, 16'hC3D4);
    step();
    send_byte("sw_next_lo", 8'h02);
    step();

    // ---------------- tx_done while idle is ignored ----------------
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    step();
    chk("idle_done_sent", resp_sent, 1'b0);
    chk("idle_done_trmt", trmt, 1'b0);

    // ---------------- three pushes, third dropped ----------------
    send_resp = 1'b1; resp = 8'hA5;
    step();
    chk("q_lat_trmt", trmt, 1'b0);
    resp = 8'h5A;
    step();
    chk("q1_trmt", trmt, 1'b1);
    chk("q1_data", tx_data, 8'hA5);
    resp = 8'hFF;
    step();
    send_resp = 1'b0;
    chk("q_drop", resp_drop, 1'b1);
    chk("q1_trmt_pulse", trmt, 1'b0);
    step();
    chk("q_drop_pulse", resp_drop, 1'b0);
    step();
    chk("q_hold_data", tx_data, 8'hA5);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("q1_sent", resp_sent, 1'b1);
    chk("q_no_b2b_trmt", trmt, 1'b0);
    step();
    chk("q2_trmt", trmt, 1'b1);
    chk("q2_data", tx_data, 8'h5A);
    chk("q_sent_pulse", resp_sent, 1'b0);
    finish_tx("q2");
    for (int k = 0; k < 4; k++) begin
      step();
      chk("q_empty_trmt", trmt, 1'b0);
    end

    // ---------------- push on full during pop ----------------
    send_resp = 1'b1; resp = 8'h11;
    step();
    resp = 8'h22;
    step();
    chk("pp1_trmt", trmt, 1'b1);
    chk("pp1_data", tx_data, 8'h11);
    resp = 8'h77;
    tx_done = 1'b1;
    step();
    send_resp = 1'b0;
    tx_done = 1'b0;
    chk("pp_sent", resp_sent, 1'b1);
    chk("pp_no_drop", resp_drop, 1'b0);
    step();
    chk("pp_no_drop2", resp_drop, 1'b0);
    chk("pp2_trmt", trmt, 1'b1);
    chk("pp2_data", tx_data, 8'h22);
    finish_tx("pp2");
    wait_trmt("pp3", 8'h77);
    finish_tx("pp3");
    step();
    step();
    chk("pp_empty_trmt", trmt, 1'b0);

    // ---------------- reset mid-frame and mid-transmit ----------------
    send_byte("mr_hi", 8'hDE);
    send_resp = 1'b1; resp = 8'h44;
    step();
    send_resp = 1'b0;
    wait_trmt("mr_tx", 8'h44);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_reset_outputs("mr");
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("mr_no_sent", resp_sent, 1'b0);
    step();
    chk("mr_no_sent2", resp_sent, 1'b0);
    chk("mr_no_trmt", trmt, 1'b0);
    send_byte("mr_b1", 8'hBE);
    chk("mr_b1_rdy", cmd_rdy, 1'b0);
    step();
    send_byte("mr_b2", 8'hEF);
    chk("mr_cmd", cmd, 16'hBEEF);
    chk("mr_rdy", cmd_rdy, 1'b1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
